wb_result_arbiter: RTL and testbench
====================================

Name: wb_result_arbiter

Overview:
- Consumer end of the multiplier result path. Merges the 5-stage multiplier's result stream and the single-cycle ALU result stream onto the single register-file write port.
- Multiplier results always win: they are older in program order and come from a pipe with no buffering.
- A small in-order FIFO absorbs conflicting ALU results.
- Generates stall_mul_out back to the multiplier pipe and stall_alu_out back to the ALU stage.

Parameters:
XLEN, 32, data width of results.
TAG_W, 4, width of instruction tag (graduation-list id).
ALU_BUF_DEPTH, 2, ALU skid FIFO entries; power of two, >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mul_valid  in  1  multiplier final-stage result valid
mul_rd  in  5  destination register
mul_data  in  XLEN  result
mul_tag  in  TAG_W  instruction tag
alu_valid  in  1  ALU result valid
alu_rd  in  5  destination register
alu_data  in  XLEN  result
alu_tag  in  TAG_W  instruction tag
kill  in  1  flush from graduation list
wb_stall_in  in  1  write port unavailable this cycle
wb_valid  out  1  registered writeback valid
wb_rd  out  5  registered destination register
wb_data  out  XLEN  registered data
wb_tag  out  TAG_W  registered tag
stall_mul_out  out  1  hold multiplier pipe (combinational)
stall_alu_out  out  1  hold ALU stage (combinational)

Behaviour:
- Reset values:
  - wb_valid=0; wb_rd, wb_data, wb_tag = 0.
  - FIFO count=0, rd_ptr=wr_ptr=0.
  - stall_mul_out=0, stall_alu_out=0.
- Stall outputs:
  - stall_mul_out = wb_stall_in & ~kill.
  - stall_alu_out = (count == ALU_BUF_DEPTH) | (wb_stall_in & ~kill).
- ALU acceptance: an ALU result is accepted only when alu_valid & ~stall_alu_out & ~kill. While stalled, the producer holds its inputs.
- Cycle priority, highest first:
  1. kill:
     - FIFO flushed (count, ptrs = 0).
     - wb_valid cleared next cycle.
     - No input accepted that cycle.
  2. wb_stall_in:
     - Output register holds its value.
     - No push, no pop.
     - mul input is not consumed; upstream holds it via stall_mul_out.
  3. Otherwise, select source:
     - mul_valid: select mul.
     - else count>0: select FIFO head and pop.
     - else accepted ALU result: select ALU directly, no FIFO entry.
     - else: wb_valid<=0.
- Push: an accepted ALU result that is not selected directly is pushed at wr_ptr. This covers mul conflicts and ordering behind older buffered entries.
- Count and pointers:
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
  - Pointers wrap modulo ALU_BUF_DEPTH.
- Latency:
  - 1 cycle from selection to wb_*.
  - The FIFO guarantees buffered ALU results leave in arrival order. An ALU result never overtakes an older buffered ALU result.
- Overflow: impossible by construction. Push never occurs while count==ALU_BUF_DEPTH.
- Reset mid-operation: buffered entries are discarded; outputs return to reset values next edge.

Optional Feature:
- Macro WB_RESULT_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_conflict_cnt (32) and perf_stall_cnt (32).
  - perf_conflict_cnt increments each non-kill, non-stall cycle with mul_valid & accepted ALU result.
  - perf_stall_cnt increments each cycle stall_alu_out=1.
  - Both cleared by rst and saturate at 0xFFFFFFFF.
- Undefined: counters and ports absent; functional behaviour identical.

Test Plan:
- Reset then idle 3 cycles -> wb_valid=0, stall_mul_out=0, stall_alu_out=0 every cycle.
- alu_valid rd=5 data=0x11 tag=2 at cycle N, no mul -> wb_valid=1 rd=5 data=0x11 tag=2 at N+1; count stays 0.
- mul rd=3 data=0xAAAA and alu rd=4 data=0xBBBB both at N -> N+1 wb rd=3 data=0xAAAA; N+2 wb rd=4 data=0xBBBB.
- DEPTH=2; mul_valid and alu_valid for 4 consecutive cycles (alu data 1,2,3,4, held while stalled):
  - stall_alu_out=1 from the third cycle.
  - After mul stops, wb emits alu 1,2,3,4 in order with no loss or duplication.
- Output holding rd=7; wb_stall_in=1 for 3 cycles with mul_valid=1:
  - wb_* unchanged and stall_mul_out=1 all 3 cycles.
  - mul result written the cycle after wb_stall_in falls.
- Two ALU entries buffered, kill=1 for one cycle -> next cycle wb_valid=0, count=0, stall_alu_out=0; buffered entries never appear on wb_*.

Source files
------------

// File: rtl/wb_result_arbiter_if.sv
// Bus bundle for wb_result_arbiter: multiplier/ALU result inputs, flush/stall controls and the writeback port.
interface wb_result_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             mul_valid;
  logic [4:0]       mul_rd;
  logic [XLEN-1:0]  mul_data;
  logic [TAG_W-1:0] mul_tag;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic [TAG_W-1:0] alu_tag;
  logic             kill;
  logic             wb_stall_in;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             stall_mul_out;
  logic             stall_alu_out;

  modport master (
    output mul_valid, mul_rd, mul_data, mul_tag,
    output alu_valid, alu_rd, alu_data, alu_tag,
    output kill, wb_stall_in,
    input  wb_valid, wb_rd, wb_data, wb_tag,
    input  stall_mul_out, stall_alu_out
  );

  modport slave (
    input  mul_valid, mul_rd, mul_data, mul_tag,
    input  alu_valid, alu_rd, alu_data, alu_tag,
    input  kill, wb_stall_in,
    output wb_valid, wb_rd, wb_data, wb_tag,
    output stall_mul_out, stall_alu_out
  );
endinterface

// File: rtl/wb_result_arbiter.sv
// Merges multiplier and ALU results onto one register-file write port; mul always wins, ALU overflow goes to an in-order FIFO.
// Optional performance counters are enabled with `define WB_RESULT_ARBITER_PERF_EN.
module wb_result_arbiter #(
  parameter int XLEN          = 32,
  parameter int TAG_W         = 4,
  parameter int ALU_BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_result_arbiter_if.slave   bus
`ifdef WB_RESULT_ARBITER_PERF_EN
  ,
  output logic [31:0]          perf_conflict_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  localparam int PTR_W = (ALU_BUF_DEPTH > 1) ? $clog2(ALU_BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(ALU_BUF_DEPTH + 1);

  logic [4:0]       r_mem_rd   [ALU_BUF_DEPTH];
  logic [XLEN-1:0]  r_mem_data [ALU_BUF_DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [ALU_BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic [TAG_W-1:0] r_wb_tag;

  logic             w_full, w_stall, w_stall_alu, w_alu_acc;
  logic             w_push, w_pop, w_sel_valid;
  logic [4:0]       w_sel_rd;
  logic [XLEN-1:0]  w_sel_data;
  logic [TAG_W-1:0] w_sel_tag;

  assign w_full      = (r_count == CNT_W'(ALU_BUF_DEPTH));
  assign w_stall     = bus.wb_stall_in & ~bus.kill;
  assign w_stall_alu = w_full | w_stall;
  assign w_alu_acc   = bus.alu_valid & ~w_stall_alu & ~bus.kill;

  assign bus.stall_mul_out = w_stall;
  assign bus.stall_alu_out = w_stall_alu;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_rd         = r_wb_rd;
  assign bus.wb_data       = r_wb_data;
  assign bus.wb_tag        = r_wb_tag;

  // An accepted ALU result bypasses the FIFO only when nothing older is waiting.
  always_comb begin
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    w_sel_tag   = '0;
    if (!bus.kill && !bus.wb_stall_in) begin
      if (bus.mul_valid) begin
        w_sel_valid = 1'b1;
        w_sel_rd    = bus.mul_rd;
        w_sel_data  = bus.mul_data;
        w_sel_tag   = bus.mul_tag;
        w_push      = w_alu_acc;
      end else if (r_count != '0) begin
        w_sel_valid = 1'b1;
        w_sel_rd    = r_mem_rd[r_rd_ptr];
        w_sel_data  = r_mem_data[r_rd_ptr];
        w_sel_tag   = r_mem_tag[r_rd_ptr];
        w_pop       = 1'b1;
        w_push      = w_alu_acc;
      end else if (w_alu_acc) begin
        w_sel_valid = 1'b1;
        w_sel_rd    = bus.alu_rd;
        w_sel_data  = bus.alu_data;
        w_sel_tag   = bus.alu_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= bus.alu_rd;
      r_mem_data[r_wr_ptr] <= bus.alu_data;
      r_mem_tag[r_wr_ptr]  <= bus.alu_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_tag   <= '0;
    end else if (bus.kill) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_wb_valid <= 1'b0;
    end else if (!bus.wb_stall_in) begin
      r_wb_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_wb_rd   <= w_sel_rd;
        r_wb_data <= w_sel_data;
        r_wb_tag  <= w_sel_tag;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

`ifdef WB_RESULT_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (bus.mul_valid && w_alu_acc && perf_conflict_cnt != 32'hFFFF_FFFF)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      if (w_stall_alu && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_result_arbiter.sv
// Directed bench for wb_result_arbiter: reset, direct ALU path, conflicts, FIFO fill/drain order, output stall, kill and reset flush.
module tb_wb_result_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_result_arbiter_if #(.XLEN(32), .TAG_W(4)) bus ();

`ifdef WB_RESULT_ARBITER_PERF_EN
  logic [31:0] perf_conflict_cnt, perf_stall_cnt;
  wb_result_arbiter #(.XLEN(32), .TAG_W(4), .ALU_BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_conflict_cnt(perf_conflict_cnt), .perf_stall_cnt(perf_stall_cnt));
`else
  wb_result_arbiter #(.XLEN(32), .TAG_W(4), .ALU_BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mul_valid = 1'b0; bus.mul_rd = '0; bus.mul_data = '0; bus.mul_tag = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0; bus.alu_tag = '0;
    bus.kill = 1'b0; bus.wb_stall_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.wb_valid !== 1'b0) begin
        errors++; $display("FAIL reset_wb_valid cyc%0d: got %b want 0", i, bus.wb_valid);
      end
      checks++;
      if (bus.stall_mul_out !== 1'b0) begin
        errors++; $display("FAIL reset_stall_mul cyc%0d: got %b want 0", i, bus.stall_mul_out);
      end
      checks++;
      if (bus.stall_alu_out !== 1'b0) begin
        errors++; $display("FAIL reset_stall_alu cyc%0d: got %b want 0", i, bus.stall_alu_out);
      end
    end
    checks++;
    if ({bus.wb_rd, bus.wb_data, bus.wb_tag} !== '0) begin
      errors++; $display("FAIL reset_wb_fields: rd=%0d data=%h tag=%0d want all 0", bus.wb_rd, bus.wb_data, bus.wb_tag);
    end
  endtask

  task automatic test_alu_direct();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11; bus.alu_tag = 4'd2;
    step();
    idle_inputs();
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag} !== {1'b1, 5'd5, 32'h11, 4'd2}) begin
      errors++; $display("FAIL alu_direct: got v=%b rd=%0d data=%h tag=%0d want v=1 rd=5 data=11 tag=2",
                         bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag);
    end
    step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_direct_no_buffer: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_conflict();
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd3; bus.mul_data = 32'hAAAA; bus.mul_tag = 4'd1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'hBBBB; bus.alu_tag = 4'd3;
    #1;
    checks++;
    if (bus.stall_alu_out !== 1'b0) begin
      errors++; $display("FAIL conflict_stall_alu: got %b want 0", bus.stall_alu_out);
    end
    step();
    idle_inputs();
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag} !== {1'b1, 5'd3, 32'hAAAA, 4'd1}) begin
      errors++; $display("FAIL conflict_mul_first: got v=%b rd=%0d data=%h tag=%0d want v=1 rd=3 data=aaaa tag=1",
                         bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag);
    end
    step();
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag} !== {1'b1, 5'd4, 32'hBBBB, 4'd3}) begin
      errors++; $display("FAIL conflict_alu_second: got v=%b rd=%0d data=%h tag=%0d want v=1 rd=4 data=bbbb tag=3",
                         bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag);
    end
    step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL conflict_drained: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_fifo_fill();
    // Producer advances only in cycles where the expected stall is low.
    logic        exp_stall [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_wb    [8] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'd1, 32'd2, 32'd3, 32'd4};
    int k = 1;
    for (int c = 0; c < 8; c++) begin
      bus.mul_valid = (c < 4);
      bus.mul_rd    = 5'd10;
      bus.mul_data  = 32'h101 + 32'(c);
      bus.mul_tag   = 4'd7;
      bus.alu_valid = (k <= 4);
      bus.alu_rd    = 5'd20;
      bus.alu_data  = 32'(k);
      bus.alu_tag   = 4'(k);
      #1;
      checks++;
      if (bus.stall_alu_out !== exp_stall[c]) begin
        errors++; $display("FAIL fifo_stall_alu cyc%0d: got %b want %b", c, bus.stall_alu_out, exp_stall[c]);
      end
      if (!exp_stall[c] && k <= 4) k++;
      step();
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_wb[c]) begin
        errors++; $display("FAIL fifo_order cyc%0d: got v=%b data=%h want v=1 data=%h", c, bus.wb_valid, bus.wb_data, exp_wb[c]);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL fifo_no_duplicate: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_wb_stall();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77; bus.alu_tag = 4'd5;
    step();
    idle_inputs();
    bus.wb_stall_in = 1'b1;
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd9; bus.mul_data = 32'h99; bus.mul_tag = 4'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.stall_mul_out !== 1'b1 || bus.stall_alu_out !== 1'b1) begin
        errors++; $display("FAIL wbstall_stall_outs cyc%0d: got mul=%b alu=%b want 1 1", i, bus.stall_mul_out, bus.stall_alu_out);
      end
      step();
      checks++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag} !== {1'b1, 5'd7, 32'h77, 4'd5}) begin
        errors++; $display("FAIL wbstall_hold cyc%0d: got v=%b rd=%0d data=%h tag=%0d want v=1 rd=7 data=77 tag=5",
                           i, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag);
      end
    end
    bus.wb_stall_in = 1'b0;
    #1;
    checks++;
    if (bus.stall_mul_out !== 1'b0) begin
      errors++; $display("FAIL wbstall_release: stall_mul_out got %b want 0", bus.stall_mul_out);
    end
    step();
    idle_inputs();
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag} !== {1'b1, 5'd9, 32'h99, 4'd6}) begin
      errors++; $display("FAIL wbstall_mul_written: got v=%b rd=%0d data=%h tag=%0d want v=1 rd=9 data=99 tag=6",
                         bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag);
    end
    step();
  endtask

  task automatic fill_two();
    for (int i = 0; i < 2; i++) begin
      bus.mul_valid = 1'b1; bus.mul_rd = 5'd1; bus.mul_data = 32'hC0 + 32'(i); bus.mul_tag = 4'd0;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'hE0 + 32'(i); bus.alu_tag = 4'd9;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_kill();
    fill_two();
    bus.kill = 1'b1;
    bus.wb_stall_in = 1'b1;
    #1;
    checks++;
    if (bus.stall_mul_out !== 1'b0) begin
      errors++; $display("FAIL kill_masks_stall_mul: got %b want 0", bus.stall_mul_out);
    end
    step();
    idle_inputs();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.stall_alu_out !== 1'b0) begin
      errors++; $display("FAIL kill_flush: got wb_valid=%b stall_alu=%b want 0 0", bus.wb_valid, bus.stall_alu_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.wb_valid !== 1'b0) begin
        errors++; $display("FAIL kill_no_leak cyc%0d: wb_valid got %b data=%h want 0", i, bus.wb_valid, bus.wb_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_two();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag, bus.stall_alu_out} !== '0) begin
      errors++; $display("FAIL reset_mid: got v=%b rd=%0d data=%h tag=%0d stall_alu=%b want all 0",
                         bus.wb_valid, bus.wb_rd, bus.wb_data, bus.wb_tag, bus.stall_alu_out);
    end
    step();
    checks++;
    if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_leak: wb_valid got %b want 0", bus.wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd11 + 5'(i); bus.alu_data = 32'h21 + 32'(i); bus.alu_tag = 4'(i);
      step();
      checks++;
      if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd11 + 5'(i), 32'h21 + 32'(i)}) begin
        errors++; $display("FAIL back_to_back cyc%0d: got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                           i, bus.wb_valid, bus.wb_rd, bus.wb_data, 11 + i, 32'h21 + 32'(i));
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_alu_direct();
    test_conflict();
    test_fifo_fill();
    test_wb_stall();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
